key_event_unit: RTL and testbench



---
 rtl/key_event_unit.sv | 182 ++++++++++++++++++
 tb/tb_key_event_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_unit.sv
// Keypad front end: synchronise and debounce raw buttons, turn debounced edges
// into {rel, code} events, and queue them in a small FIFO read one byte at a time.
module key_event_unit #(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic                ctrl_we,
    input  logic [7:0]          ctrl_din,
    input  logic                pop,
    output logic [7:0]          key_read,
    output logic                key_int,
    output logic [NUM_KEYS-1:0] key_state
);

    localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned   AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    CNT_LAST  = 8'(STABLE_SAMPLES - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    logic [2:0]          r_ctrl;
    logic [NUM_KEYS-1:0] r_sync1, r_sync2;
    logic [TW-1:0]       r_tick_cnt;
    logic [7:0]          r_db_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_pend, r_pend_rel;
    logic [3:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [AW:0]         r_count;
    logic                r_ovf;
    logic                r_int;

    logic                w_tick;
    logic [NUM_KEYS-1:0] w_toggle;
    logic [NUM_KEYS-1:0] w_pend_nxt, w_rel_nxt;
    logic                w_found;
    logic                w_push_req;
    logic [2:0]          w_push_code;
    logic                w_push_rel;
    logic                w_clear, w_disable;
    logic                w_empty, w_full;
    logic                w_pop_ok, w_push_ok, w_drop;
    logic [3:0]          w_head;
    logic                w_unused_ctrl;

    assign w_clear       = ctrl_we & ctrl_din[7];
    assign w_disable     = ctrl_we & ~ctrl_din[0];
    assign w_unused_ctrl = ^ctrl_din[6:3];
    assign w_tick        = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= keys_raw;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (ctrl_we)
                r_ctrl <= ctrl_din[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++)
                r_db_cnt[k] <= '0;
        end else if (w_tick) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (r_sync2[k] == r_stable[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == CNT_LAST) begin
                    r_stable[k] <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_toggle = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++)
            w_toggle[k] = w_tick && (r_sync2[k] != r_stable[k]) && (r_db_cnt[k] == CNT_LAST);
    end

    // Drain the lowest pending key first; a fresh toggle on the same key wins over its drain.
    always_comb begin
        w_pend_nxt  = r_pend;
        w_rel_nxt   = r_pend_rel;
        w_found     = 1'b0;
        w_push_req  = 1'b0;
        w_push_code = '0;
        w_push_rel  = 1'b0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (!w_found && r_pend[k]) begin
                w_found       = 1'b1;
                w_push_req    = 1'b1;
                w_push_code   = 3'(k);
                w_push_rel    = r_pend_rel[k];
                w_pend_nxt[k] = 1'b0;
            end
        end
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (r_ctrl[0] && w_toggle[k]) begin
                if (!r_stable[k]) begin
                    w_pend_nxt[k] = 1'b1;
                    w_rel_nxt[k]  = 1'b0;
                end else if (r_ctrl[2]) begin
                    w_pend_nxt[k] = 1'b1;
                    w_rel_nxt[k]  = 1'b1;
                end
            end
        end
        if (w_clear || w_disable)
            w_pend_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_rel <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_rel <= w_rel_nxt;
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop_ok  = pop && !w_empty;
    assign w_push_ok = w_push_req && (!w_full || w_pop_ok);
    assign w_drop    = w_push_req && w_full && !w_pop_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_int    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_int    <= 1'b0;
        end else begin
            r_int <= w_push_ok && r_ctrl[1];
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= {w_push_rel, w_push_code};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + (AW+1)'(1);
            else if (!w_push_ok && w_pop_ok)
                r_count <= r_count - (AW+1)'(1);
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign key_read  = {!w_empty, r_ovf, w_empty ? 1'b0 : w_head[3], 2'b00,
                        w_empty ? 3'b000 : w_head[2:0]};
    assign key_int   = r_int;
    assign key_state = r_stable;

endmodule

// File: tb/tb_key_event_unit.sv
// Scoreboard bench for key_event_unit with a short tick (4 clocks) and 3-sample debounce.
module tb_key_event_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keys_raw;
    logic       ctrl_we;
    logic [7:0] ctrl_din;
    logic       pop;
    logic [7:0] key_read;
    logic       key_int;
    logic [3:0] key_state;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   int_cnt = 0;
    int   ib;
    logic exp_ovf;
    logic [7:0] exp_q [$];

    key_event_unit #(
        .NUM_KEYS(4), .TICK_DIV(4), .STABLE_SAMPLES(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .keys_raw(keys_raw), .ctrl_we(ctrl_we),
        .ctrl_din(ctrl_din), .pop(pop), .key_read(key_read),
        .key_int(key_int), .key_state(key_state)
    );

    always #5 clk = ~clk;

    // Edge count since the last reset edge; debounce ticks land on multiples of 4.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_int === 1'b1) int_cnt <= int_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        if (cyc > n) chk("sched", 32'(cyc), 32'(n));
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; keys_raw = '0; ctrl_we = 1'b0; ctrl_din = '0; pop = 1'b0;
        exp_q.delete(); exp_ovf = 1'b0;
        step();
        rst = 1'b0;
        ib = int_cnt;
    endtask

    task automatic wr_ctrl(input logic [7:0] v);
        ctrl_din = v; ctrl_we = 1'b1;
        step();
        ctrl_we = 1'b0;
    endtask

    task automatic read_chk(input string tag);
        logic [7:0] e;
        chk({tag, "_sbq"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (exp_ovf) e = e | 8'h40;
            chk(tag, 32'(key_read), 32'(e));
        end
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        do_reset();
        chk("rst_read", 32'(key_read), 32'h00);
        chk("rst_int", 32'(key_int), 32'h0);
        chk("rst_state", 32'(key_state), 32'h0);

        // reset one cycle before acceptance, key still held afterwards
        wr_ctrl(8'h03);
        wait_cyc(4);  keys_raw = 4'b0010;
        wait_cyc(15); chk("s1_pre_state", 32'(key_state), 32'h0);
        rst = 1'b1; #1;
        chk("s1_rst_state", 32'(key_state), 32'h0);
        chk("s1_rst_read", 32'(key_read), 32'h00);
        chk("s1_rst_int", 32'(key_int), 32'h0);
        step(); rst = 1'b0;
        ib = int_cnt;
        wr_ctrl(8'h03);
        exp_q.push_back(8'h81);
        wait_cyc(11); chk("s1_early", 32'(key_state), 32'h0);
        wait_cyc(12); chk("s1_state", 32'(key_state), 32'h2);
        chk("s1_read_pre", 32'(key_read), 32'h00);
        wait_cyc(13); chk("s1_int", 32'(key_int), 32'h1);
        read_chk("s1_ev");
        chk("s1_int_total", 32'(int_cnt - ib), 32'd1);

        // bounce restarts the count
        do_reset();
        wr_ctrl(8'h03);
        wait_cyc(4);  keys_raw = 4'b0001;
        wait_cyc(8);  keys_raw = 4'b0000;
        wait_cyc(12); keys_raw = 4'b0001;
        exp_q.push_back(8'h80);
        wait_cyc(23);
        chk("s2_early_state", 32'(key_state), 32'h0);
        chk("s2_early_int", 32'(int_cnt - ib), 32'd0);
        wait_cyc(24); chk("s2_state", 32'(key_state), 32'h1);
        wait_cyc(25); chk("s2_int", 32'(key_int), 32'h1);
        read_chk("s2_ev");
        chk("s2_int_total", 32'(int_cnt - ib), 32'd1);

        // press and release events with rel_en on, then off
        do_reset();
        wr_ctrl(8'h07);
        wait_cyc(4);  keys_raw = 4'b0100;
        exp_q.push_back(8'h82);
        wait_cyc(20); keys_raw = 4'b0000;
        exp_q.push_back(8'hA2);
        wait_cyc(34);
        read_chk("s3_press");
        read_chk("s3_release");
        chk("s3_empty", 32'(key_read), 32'h00);
        chk("s3_int_total", 32'(int_cnt - ib), 32'd2);

        do_reset();
        wr_ctrl(8'h03);
        wait_cyc(4);  keys_raw = 4'b0100;
        exp_q.push_back(8'h82);
        wait_cyc(20); keys_raw = 4'b0000;
        wait_cyc(36);
        chk("s3b_state", 32'(key_state), 32'h0);
        read_chk("s3b_press");
        chk("s3b_empty", 32'(key_read), 32'h00);
        chk("s3b_int_total", 32'(int_cnt - ib), 32'd1);

        // two keys accepted on the same tick
        do_reset();
        wr_ctrl(8'h03);
        wait_cyc(4);  keys_raw = 4'b1001;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h83);
        wait_cyc(16);
        chk("s4_state", 32'(key_state), 32'h9);
        chk("s4_int_t16", 32'(key_int), 32'h0);
        wait_cyc(17);
        chk("s4_int_t17", 32'(key_int), 32'h1);
        chk("s4_head", 32'(key_read), 32'h80);
        wait_cyc(18); chk("s4_int_t18", 32'(key_int), 32'h1);
        wait_cyc(19); chk("s4_int_t19", 32'(key_int), 32'h0);
        read_chk("s4_ev0");
        read_chk("s4_ev3");
        chk("s4_int_total", 32'(int_cnt - ib), 32'd2);

        // overflow on fifth event, then push+pop while full
        do_reset();
        wr_ctrl(8'h03);
        wait_cyc(4);  keys_raw = 4'b1111;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 | 8'(i));
        wait_cyc(20); keys_raw = 4'b1110;
        wait_cyc(36); keys_raw = 4'b1111;
        wait_cyc(49);
        chk("s5_drop_int", 32'(key_int), 32'h0);
        chk("s5_ovf_read", 32'(key_read), 32'hC0);
        chk("s5_int_four", 32'(int_cnt - ib), 32'd4);
        exp_ovf = 1'b1;
        wait_cyc(52); keys_raw = 4'b1110;
        wait_cyc(68); keys_raw = 4'b1111;
        exp_q.push_back(8'h80);
        wait_cyc(80);
        read_chk("s5_pp");
        chk("s5_pp_int", 32'(key_int), 32'h1);
        for (int i = 0; i < 4; i++) read_chk($sformatf("s5_drain%0d", i));
        chk("s5_empty_ovf", 32'(key_read), 32'h40);
        chk("s5_int_total", 32'(int_cnt - ib), 32'd5);

        // pop on empty, then clear racing a push and a pop
        do_reset();
        wr_ctrl(8'h03);
        pop = 1'b1; step(); pop = 1'b0;
        chk("s6_pop_empty", 32'(key_read), 32'h00);
        chk("s6_pop_empty_int", 32'(key_int), 32'h0);
        wait_cyc(4);  keys_raw = 4'b0011;
        wait_cyc(17);
        chk("s6_head", 32'(key_read), 32'h80);
        chk("s6_int1", 32'(key_int), 32'h1);
        ctrl_din = 8'h83; ctrl_we = 1'b1; pop = 1'b1;
        step();
        ctrl_we = 1'b0; pop = 1'b0;
        chk("s6_clr_read", 32'(key_read), 32'h00);
        chk("s6_clr_int", 32'(key_int), 32'h0);
        step();
        chk("s6_clr_read2", 32'(key_read), 32'h00);
        chk("s6_clr_int2", 32'(key_int), 32'h0);
        chk("s6_int_total", 32'(int_cnt - ib), 32'd1);
        chk("s6_state", 32'(key_state), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
